stall_mem_resp: RTL and testbench

- Multi-cycle data-memory responder: the target end of the Rd/Wr → Stall/Done handshake driven by the processor's memory stage.
- Accepts one word-aligned 16-bit read or write at a time and holds the initiator in Stall for a fixed latency.
- Pulses Done with read data, and flags illegal requests on err.
- Backs the memory stage in place of an ideal single-cycle memory.

---
 rtl/stall_mem_resp.sv | 148 ++++++++++++++
 tb/tb_stall_mem_resp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stall_mem_resp.sv
// Multi-cycle data-memory responder: holds the initiator in Stall for LATENCY cycles, then pulses Done.
// Optional one-entry read tag for single-cycle hits is enabled with `define STALLMEM_HIT_EN.
module stall_mem_resp #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [3:0] LastCount = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, stateNext;
  logic [3:0]            counter, counterNext;
  logic [DEPTH_LOG2-1:0] latIdx;
  logic [15:0]           latData;
  logic                  latWrite;
  logic [15:0]           mem [DEPTH];

  logic                  request, illegal, legalReq, hitNow;
  logic                  accept, complete, hitTake, cWrite;
  logic [DEPTH_LOG2-1:0] reqIdx, cIdx;
  logic [15:0]           cData;
  logic                  unusedAddrBits;

  assign request  = Rd | Wr;
  assign illegal  = (Rd & Wr) | (request & Addr[0]);
  assign legalReq = request & ~illegal;
  assign reqIdx   = Addr[DEPTH_LOG2:1];
  // Upper address bits alias onto the same words by design.
  assign unusedAddrBits = ^Addr[15:DEPTH_LOG2+1];

`ifdef STALLMEM_HIT_EN
  logic                  tagValid;
  logic [DEPTH_LOG2-1:0] tagIdx;

  assign hitNow = Rd & tagValid & (tagIdx == reqIdx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tagValid <= 1'b0;
      tagIdx   <= '0;
    end else if (complete) begin
      tagValid <= 1'b1;
      tagIdx   <= cIdx;
    end
  end
`else
  assign hitNow = 1'b0;
`endif

  always_comb begin
    stateNext   = state;
    counterNext = counter;
    Stall       = 1'b0;
    err         = 1'b0;
    accept      = 1'b0;
    complete    = 1'b0;
    hitTake     = 1'b0;
    cIdx        = latIdx;
    cData       = latData;
    cWrite      = latWrite;
    case (state)
      IDLE: begin
        err   = illegal;
        Stall = legalReq;
        if (legalReq) begin
          accept = 1'b1;
          if (LATENCY == 1 || hitNow) begin
            // Completing on the acceptance edge: use the live request, not the latches.
            stateNext = DONE;
            complete  = 1'b1;
            hitTake   = hitNow;
            cIdx      = reqIdx;
            cData     = DataIn;
            cWrite    = Wr;
          end else begin
            stateNext   = BUSY;
            counterNext = 4'd1;
          end
        end
      end
      BUSY: begin
        Stall       = 1'b1;
        counterNext = counter + 4'd1;
        if (counter == LastCount) begin
          stateNext   = DONE;
          complete    = 1'b1;
          counterNext = 4'd0;
        end
      end
      DONE: begin
        stateNext   = IDLE;
        counterNext = 4'd0;
      end
      default: begin
        stateNext   = IDLE;
        counterNext = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      counter  <= 4'd0;
      latIdx   <= '0;
      latData  <= 16'd0;
      latWrite <= 1'b0;
      Done     <= 1'b0;
      CacheHit <= 1'b0;
      DataOut  <= 16'd0;
    end else begin
      state    <= stateNext;
      counter  <= counterNext;
      Done     <= complete;
      CacheHit <= hitTake;
      if (accept) begin
        latIdx   <= reqIdx;
        latData  <= DataIn;
        latWrite <= Wr;
      end
      if (complete && !cWrite) begin
        DataOut <= mem[cIdx];
      end
    end
  end

  // Array is never cleared; an aborted write never reaches this edge.
  always_ff @(posedge clk) begin
    if (complete && cWrite) begin
      mem[cIdx] <= cData;
    end
  end

endmodule

// File: tb/tb_stall_mem_resp.sv
// Self-checking bench for stall_mem_resp: directed scenarios plus randomized traffic against a word-array model.
module tb_stall_mem_resp;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0, dataIn = '0, dataOut;
  logic        rd = 1'b0, wr = 1'b0, done, stall, cacheHit, err;
  logic [15:0] addr1 = '0, dataIn1 = '0, dataOut1;
  logic        rd1 = 1'b0, wr1 = 1'b0, done1, stall1, cacheHit1, err1;

  int passCnt = 0;
  int totalCnt = 0;

  logic [15:0] mMem [256];
  bit          mKnown [256];
  logic [15:0] mOut = '0;
  bit          mTagValid = 0;
  int          mTagIdx = 0;

  always #5 clk = ~clk;

  stall_mem_resp #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst), .Addr(addr), .DataIn(dataIn), .Rd(rd), .Wr(wr),
    .DataOut(dataOut), .Done(done), .Stall(stall), .CacheHit(cacheHit), .err(err)
  );

  stall_mem_resp #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
    .clk(clk), .rst(rst), .Addr(addr1), .DataIn(dataIn1), .Rd(rd1), .Wr(wr1),
    .DataOut(dataOut1), .Done(done1), .Stall(stall1), .CacheHit(cacheHit1), .err(err1)
  );

  function automatic int idxOf(input logic [15:0] a);
    return int'(a[8:1]);
  endfunction

  function automatic bit modelHit(input bit isRead, input int idx);
`ifdef STALLMEM_HIT_EN
    return isRead && mTagValid && (mTagIdx == idx);
`else
    return 1'b0;
`endif
  endfunction

  task automatic modelApply(input bit isRead, input int idx, input logic [15:0] d);
    if (isRead) mOut = mMem[idx];
    else begin
      mMem[idx]   = d;
      mKnown[idx] = 1'b1;
    end
    mTagValid = 1'b1;
    mTagIdx   = idx;
  endtask

  // Drives one held request until Done (bounded), reporting what was observed.
  task automatic runTxn(input bit isRead, input logic [15:0] a, input logic [15:0] d,
                        input bit scramble, output int lat, output bit stallBad,
                        output logic [15:0] dout, output logic hit, output logic doneAfter);
    rd = isRead; wr = !isRead; addr = a; dataIn = d;
    lat = -1; stallBad = 1'b0; dout = '0; hit = 1'b0; doneAfter = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c; dout = dataOut; hit = cacheHit;
        if (stall !== 1'b0) stallBad = 1'b1;
        break;
      end
      if (stall !== 1'b1 || err !== 1'b0) stallBad = 1'b1;
      @(posedge clk); #1;
      if (scramble) begin addr = 16'($urandom); dataIn = 16'($urandom); end
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    doneAfter = done;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    totalCnt++; if ({done, stall, cacheHit, err} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {done, stall, cacheHit, err}); else passCnt++;
    totalCnt++; if (dataOut !== 16'h0) $display("FAIL reset_dataout got %h want 0000", dataOut); else passCnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    mOut = '0; mTagValid = 1'b0;
  endtask

  // One model-checked transaction; used by directed tests for a given address/data.
  task automatic checkedTxn(input string name, input bit isRead, input logic [15:0] a,
                            input logic [15:0] d, input bit scramble);
    int lat; bit stallBad; logic [15:0] dout; logic hit, doneAfter;
    int idx; bit eHit; int eLat;
    idx  = idxOf(a);
    eHit = modelHit(isRead, idx);
    eLat = eHit ? 1 : LAT;
    runTxn(isRead, a, d, scramble, lat, stallBad, dout, hit, doneAfter);
    modelApply(isRead, idx, d);
    totalCnt++; if (lat !== eLat) $display("FAIL %s_latency got %0d want %0d", name, lat, eLat); else passCnt++;
    totalCnt++; if (stallBad !== 1'b0) $display("FAIL %s_stall got bad_profile want stall_until_done", name); else passCnt++;
    totalCnt++; if (hit !== eHit) $display("FAIL %s_cachehit got %b want %b", name, hit, eHit); else passCnt++;
    totalCnt++; if (doneAfter !== 1'b0) $display("FAIL %s_done_width got %b want 0", name, doneAfter); else passCnt++;
    totalCnt++; if (dout !== mOut) $display("FAIL %s_dataout got %h want %h", name, dout, mOut); else passCnt++;
    $display("txn %s %s addr=%h data=%h lat=%0d dout=%h hit=%b", name, isRead ? "RD" : "WR", a, d, lat, dout, hit);
  endtask

  task automatic test_write_read;
    checkedTxn("wr_beef", 1'b0, 16'h0010, 16'hBEEF, 1'b0);
    checkedTxn("rd_beef", 1'b1, 16'h0010, 16'h0000, 1'b0);
    checkedTxn("rd_beef_again", 1'b1, 16'h0010, 16'h0000, 1'b0);
  endtask

  task automatic test_alias;
    checkedTxn("wr_alias", 1'b0, 16'h0202, 16'h1234, 1'b0);
    checkedTxn("rd_alias", 1'b1, 16'h0002, 16'h0000, 1'b0);
  endtask

  task automatic test_illegal;
    logic [2:0] cases [3];
    cases[0] = 3'b110; cases[1] = 3'b011; cases[2] = 3'b101;   // {rd, wr, odd}
    for (int k = 0; k < 3; k++) begin
      logic [2:0] cs;
      cs = cases[k];
      rd = cs[2]; wr = cs[1]; addr = cs[0] ? 16'h0011 : 16'h0010; dataIn = 16'hDEAD;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        totalCnt++; if (err !== 1'b1) $display("FAIL illegal%0d_err got %b want 1", k, err); else passCnt++;
        totalCnt++; if ({stall, done} !== 2'b00) $display("FAIL illegal%0d_stall_done got %b want 00", k, {stall, done}); else passCnt++;
        @(posedge clk); #1;
      end
      rd = 1'b0; wr = 1'b0;
      $display("txn illegal%0d rd=%b wr=%b addr=%h", k, cs[2], cs[1], addr);
    end
    checkedTxn("rd_after_illegal", 1'b1, 16'h0010, 16'h0000, 1'b0);
  endtask

  task automatic test_async_reset;
    checkedTxn("wr_pre", 1'b0, 16'h0020, 16'h1111, 1'b0);
    checkedTxn("rd_nonzero", 1'b1, 16'h0202, 16'h0000, 1'b0);
    rd = 1'b0; wr = 1'b1; addr = 16'h0020; dataIn = 16'h5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst = 1'b0; wr = 1'b0;
    #1;
    totalCnt++; if ({done, stall, cacheHit, err} !== 4'b0) $display("FAIL abort_flags got %b want 0000", {done, stall, cacheHit, err}); else passCnt++;
    totalCnt++; if (dataOut !== 16'h0) $display("FAIL abort_dataout got %h want 0000", dataOut); else passCnt++;
    mOut = '0; mTagValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    $display("txn aborted write addr=0020 data=5555");
    checkedTxn("rd_after_abort", 1'b1, 16'h0020, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back;
    wr1 = 1'b1; addr1 = 16'h0040; dataIn1 = 16'hA5A5;
    @(negedge clk);
    totalCnt++; if (stall1 !== 1'b1) $display("FAIL b2b_wr_stall got %b want 1", stall1); else passCnt++;
    @(posedge clk); #1;
    @(negedge clk);
    totalCnt++; if (done1 !== 1'b1) $display("FAIL b2b_wr_done got %b want 1", done1); else passCnt++;
    @(posedge clk); #1;
    wr1 = 1'b0; rd1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bit eDone;
      eDone = (c % 2) == 1;
      @(negedge clk);
      totalCnt++; if (done1 !== eDone) $display("FAIL b2b_done%0d got %b want %b", c, done1, eDone); else passCnt++;
      totalCnt++; if (stall1 !== !eDone) $display("FAIL b2b_stall%0d got %b want %b", c, stall1, !eDone); else passCnt++;
      if (eDone) begin
        totalCnt++; if (dataOut1 !== 16'hA5A5) $display("FAIL b2b_data%0d got %h want a5a5", c, dataOut1); else passCnt++;
      end
      $display("txn b2b cycle=%0d done=%b stall=%b dout=%h", c, done1, stall1, dataOut1);
      @(posedge clk); #1;
    end
    rd1 = 1'b0;
  endtask

  task automatic test_random;
    int words [8];
    words = '{3, 17, 40, 77, 100, 128, 200, 255};
    for (int i = 0; i < 8; i++) begin
      checkedTxn("rnd_init", 1'b0, 16'((($urandom & 32'h7F) << 9) | (words[i] << 1)), 16'($urandom), 1'b0);
    end
    for (int n = 0; n < 40; n++) begin
      int w;
      bit isRead;
      w = words[$urandom_range(0, 7)];
      isRead = ($urandom_range(0, 2) != 0);
      checkedTxn("rnd", isRead, 16'((($urandom & 32'h7F) << 9) | (w << 1)), 16'($urandom), 1'b1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mMem[i] = 'x; mKnown[i] = 1'b0; end
    test_reset();
    test_write_read();
    test_alias();
    test_illegal();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
